dice_roller: RTL and testbench

Player-side roll generator for the two-player dice game. It debounces the roll button and animates two dice for a fixed interval. It then presents the dice sum on `num` together with the current player on `turn`, and alternates players once the rules engine has consumed each roll. It sits directly in front of the rules engine: it drives that engine's `num`/`turn` inputs and obeys its `en_count` and `game_over` outputs.

---
 rtl/dice_roller.sv | 148 ++++++++++++++
 tb/tb_dice_roller.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// Roll generator for the two-player dice game: debounces the roll button, animates two
// dice, presents their sum to the rules engine and hands the turn over once it is consumed.
module dice_roller #(
   parameter int DEBOUNCE    = 16,
   parameter int ROLL_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       roll_btn,
   input  logic       en_count,
   input  logic       game_over,
   output logic [4:0] num,
   output logic [3:0] turn,
   output logic [2:0] die1,
   output logic [2:0] die2,
   output logic       busy,
   output logic [7:0] roll_count
);

   localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int RC_W = $clog2(ROLL_CYCLES + 1);
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [2:0] {
      IDLE,
      ROLL,
      SHOW,
      SETTLE,
      NEXT,
      DONE
   } state_t;

   state_t            state;
   logic              btn_s;
   logic              db_level;
   logic              db_prev;
   logic [DB_W-1:0]   db_cnt;
   logic              press;
   logic [RC_W-1:0]   roll_cnt;
   logic [15:0]       lfsr;
   logic              lfsr_fb;
   logic              dice_act;
   logic [2:0]        d1_nxt;
   logic [2:0]        d2_nxt;
   logic [4:0]        sum_nxt;

   function automatic logic [2:0] face_inc(input logic [2:0] f);
      return (f == 3'd6) ? 3'd1 : f + 3'd1;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   // Debounce: a level change is accepted only after DEBOUNCE consecutive mismatching samples
   always_ff @(posedge clk) begin
      if (!rst) begin
         btn_s    <= 1'b0;
         db_level <= 1'b0;
         db_prev  <= 1'b0;
         db_cnt   <= '0;
      end else begin
         btn_s   <= roll_btn;
         db_prev <= db_level;
         if (btn_s == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
            db_level <= btn_s;
            db_cnt   <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign press   = db_level & ~db_prev;
   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   // The latched sum uses the face values the dice take on the latching edge
   always_comb begin
      dice_act = (state == IDLE) || (state == ROLL);
      d1_nxt   = dice_act ? face_inc(die1) : die1;
      d2_nxt   = (dice_act && lfsr[0]) ? face_inc(die2) : die2;
      sum_nxt  = {2'b00, d1_nxt} + {2'b00, d2_nxt};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         num        <= 5'd0;
         turn       <= 4'd1;
         die1       <= 3'd1;
         die2       <= 3'd1;
         busy       <= 1'b0;
         roll_count <= 8'd0;
         roll_cnt   <= '0;
         lfsr       <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr_fb, lfsr[15:1]};
         die1 <= d1_nxt;
         die2 <= d2_nxt;
         case (state)
            IDLE: begin
               if (game_over) begin
                  state <= DONE;
               end else if (press && !en_count) begin
                  state    <= ROLL;
                  busy     <= 1'b1;
                  roll_cnt <= RC_W'(ROLL_CYCLES);
               end
            end
            ROLL: begin
               if (game_over) begin
                  state <= DONE;
                  busy  <= 1'b0;
               end else if (roll_cnt == RC_W'(1)) begin
                  num        <= sum_nxt;
                  roll_count <= sat_inc(roll_count);
                  state      <= SHOW;
               end else begin
                  roll_cnt <= roll_cnt - 1'b1;
               end
            end
            SHOW: begin
               if (en_count) state <= SETTLE;
            end
            SETTLE: begin
               busy  <= 1'b0;
               state <= game_over ? DONE : NEXT;
            end
            NEXT: begin
               // num clears on the same edge the turn flips, never leaving a stale sum
               num   <= 5'd0;
               turn  <= (turn == 4'd1) ? 4'd2 : 4'd1;
               state <= IDLE;
            end
            DONE: begin
               busy <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller: a dice/LFSR reference model predicts each latched
// roll into a scoreboard queue; scenario tasks check timing, handoff, game over and reset.
module tb_dice_roller;

   logic       clk;
   logic       rst;
   logic       roll_btn;
   logic       en_count;
   logic       game_over;
   logic [4:0] num;
   logic [3:0] turn;
   logic [2:0] die1;
   logic [2:0] die2;
   logic       busy;
   logic [7:0] roll_count;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [2:0] d1;
      logic [2:0] d2;
      logic [4:0] sum;
   } exp_t;

   exp_t sb[$];

   logic [15:0] m_lfsr;
   logic [2:0]  m_d1;
   logic [2:0]  m_d2;
   bit          m_act = 1'b1;

   dice_roller #(.DEBOUNCE(16), .ROLL_CYCLES(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .roll_btn   (roll_btn),
      .en_count   (en_count),
      .game_over  (game_over),
      .num        (num),
      .turn       (turn),
      .die1       (die1),
      .die2       (die2),
      .busy       (busy),
      .roll_count (roll_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] inc6(input logic [2:0] f);
      return (f >= 3'd6) ? 3'd1 : f + 3'd1;
   endfunction

   // Reference dice: LFSR free-runs; faces advance only while m_act says the game is animating
   always @(posedge clk) begin
      if (!rst) begin
         m_lfsr <= 16'hACE1;
         m_d1   <= 3'd1;
         m_d2   <= 3'd1;
      end else begin
         if (m_act) begin
            m_d1 <= inc6(m_d1);
            if (m_lfsr[0]) m_d2 <= inc6(m_d2);
         end
         m_lfsr <= (m_lfsr >> 1) |
                   ({15'd0, m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5]} << 15);
      end
   end

   function automatic exp_t predict(input int k);
      logic [15:0] l;
      logic [2:0]  a;
      logic [2:0]  b;
      logic        fb;
      exp_t        e;
      l = m_lfsr;
      a = m_d1;
      b = m_d2;
      for (int i = 0; i < k; i++) begin
         if (l[0]) b = inc6(b);
         a  = inc6(a);
         fb = l[0] ^ l[2] ^ l[3] ^ l[5];
         l  = (l >> 1) | ({15'd0, fb} << 15);
      end
      e.d1  = a;
      e.d2  = b;
      e.sum = 5'(a) + 5'(b);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst       = 1'b0;
      roll_btn  = 1'b0;
      en_count  = 1'b0;
      game_over = 1'b0;
      m_act     = 1'b1;
      sb.delete();
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Press rises now; the latch lands 26 edges later (17 debounce + 1 + 8 roll)
   task automatic press_and_push();
      sb.push_back(predict(26));
      roll_btn = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      roll_btn = 1'b0;
      en_count = 1'b0;
      game_over = 1'b0;
      m_act = 1'b1;
      tick();
      tests++;
      if (num !== 5'd0 || turn !== 4'd1 || busy !== 1'b0 || roll_count !== 8'd0) begin
         fails++;
         $display("FAIL reset_outputs: num=%0d turn=%0d busy=%0d count=%0d, want 0 1 0 0",
                  num, turn, busy, roll_count);
      end
      tests++;
      if (die1 !== 3'd1 || die2 !== 3'd1) begin
         fails++;
         $display("FAIL reset_dice: die1=%0d die2=%0d, want 1 1", die1, die2);
      end
      tick();
      rst = 1'b1;
      tick();
      tests++;
      if (die1 !== m_d1 || die2 !== m_d2) begin
         fails++;
         $display("FAIL idle_dice_step: die1=%0d die2=%0d, want %0d %0d", die1, die2, m_d1, m_d2);
      end
   endtask

   task automatic test_bounce_roll();
      int   bad;
      exp_t e;
      apply_reset();
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         roll_btn = ((i / 3) % 2 == 0);
         tick();
         if (busy !== 1'b0) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL bounce_reject: busy seen %0d cycles, want 0", bad);
      end
      press_and_push();
      bad = 0;
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (busy !== 1'b0) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL press_early: busy seen %0d cycles before edge 18, want 0", bad);
      end
      tick();
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL press_latency: busy=%0d at edge 18, want 1", busy);
      end
      bad = 0;
      for (int k = 19; k <= 25; k++) begin
         tick();
         if (busy !== 1'b1 || num !== 5'd0) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL roll_phase: %0d bad cycles (busy=0 or num!=0), want 0", bad);
      end
      tick();
      m_act = 1'b0;
      e = sb.pop_front();
      tests++;
      if (num !== e.sum || die1 !== e.d1 || die2 !== e.d2) begin
         fails++;
         $display("FAIL roll_latch: num=%0d die1=%0d die2=%0d, want %0d %0d %0d",
                  num, die1, die2, e.sum, e.d1, e.d2);
      end
      tests++;
      if (roll_count !== 8'd1 || busy !== 1'b1 || turn !== 4'd1) begin
         fails++;
         $display("FAIL roll_status: count=%0d busy=%0d turn=%0d, want 1 1 1",
                  roll_count, busy, turn);
      end
      sb.push_front(e);
      tick();
      tick();
      tick();
      tests++;
      if (num !== e.sum || die1 !== e.d1 || die2 !== e.d2 || busy !== 1'b1) begin
         fails++;
         $display("FAIL show_hold: num=%0d die1=%0d die2=%0d busy=%0d, want %0d %0d %0d 1",
                  num, die1, die2, busy, e.sum, e.d1, e.d2);
      end
   endtask

   task automatic test_turn_handoff();
      exp_t e;
      e = sb.pop_front();
      en_count = 1'b1;
      tick();
      tests++;
      if (busy !== 1'b1 || num !== e.sum) begin
         fails++;
         $display("FAIL settle: busy=%0d num=%0d, want 1 %0d", busy, num, e.sum);
      end
      tick();
      tests++;
      if (busy !== 1'b0 || num !== e.sum || turn !== 4'd1) begin
         fails++;
         $display("FAIL next: busy=%0d num=%0d turn=%0d, want 0 %0d 1", busy, num, turn, e.sum);
      end
      tick();
      m_act = 1'b1;
      tests++;
      if (num !== 5'd0 || turn !== 4'd2 || busy !== 1'b0) begin
         fails++;
         $display("FAIL handoff: num=%0d turn=%0d busy=%0d, want 0 2 0", num, turn, busy);
      end
      tests++;
      if (die1 !== m_d1 || die2 !== m_d2) begin
         fails++;
         $display("FAIL dice_frozen: die1=%0d die2=%0d, want %0d %0d", die1, die2, m_d1, m_d2);
      end
      en_count = 1'b0;
   endtask

   task automatic test_held_button();
      int bad;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (busy !== 1'b0) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL held_single_press: busy seen %0d cycles, want 0", bad);
      end
      tests++;
      if (die1 !== m_d1 || die2 !== m_d2) begin
         fails++;
         $display("FAIL idle_dice_run: die1=%0d die2=%0d, want %0d %0d", die1, die2, m_d1, m_d2);
      end
   endtask

   task automatic test_second_roll();
      exp_t e;
      roll_btn = 1'b0;
      for (int i = 0; i < 25; i++) tick();
      press_and_push();
      for (int k = 1; k <= 26; k++) tick();
      m_act = 1'b0;
      e = sb.pop_front();
      tests++;
      if (num !== e.sum || die1 !== e.d1 || die2 !== e.d2) begin
         fails++;
         $display("FAIL second_latch: num=%0d die1=%0d die2=%0d, want %0d %0d %0d",
                  num, die1, die2, e.sum, e.d1, e.d2);
      end
      tests++;
      if (turn !== 4'd2 || roll_count !== 8'd2) begin
         fails++;
         $display("FAIL second_status: turn=%0d count=%0d, want 2 2", turn, roll_count);
      end
   endtask

   task automatic test_game_over();
      exp_t e;
      int   bad;
      apply_reset();
      press_and_push();
      for (int k = 1; k <= 26; k++) tick();
      m_act = 1'b0;
      e = sb.pop_front();
      tick();
      tick();
      en_count = 1'b1;
      tick();
      game_over = 1'b1;
      tick();
      tests++;
      if (busy !== 1'b0 || num !== e.sum || turn !== 4'd1) begin
         fails++;
         $display("FAIL done_entry: busy=%0d num=%0d turn=%0d, want 0 %0d 1",
                  busy, num, turn, e.sum);
      end
      en_count = 1'b0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         roll_btn = ((i % 40) < 20);
         tick();
         if (busy !== 1'b0 || num !== e.sum || turn !== 4'd1 ||
             die1 !== e.d1 || die2 !== e.d2 || roll_count !== 8'd1) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL done_hold: %0d cycles changed in DONE, want 0", bad);
      end
   endtask

   task automatic test_blocked();
      int bad;
      apply_reset();
      en_count = 1'b1;
      roll_btn = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      tests++;
      if (busy !== 1'b0 || num !== 5'd0 || roll_count !== 8'd0) begin
         fails++;
         $display("FAIL blocked_press: busy=%0d num=%0d count=%0d, want 0 0 0",
                  busy, num, roll_count);
      end
      en_count = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (busy !== 1'b0) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL press_not_queued: busy seen %0d cycles, want 0", bad);
      end
      tests++;
      if (die1 !== m_d1 || die2 !== m_d2) begin
         fails++;
         $display("FAIL blocked_dice: die1=%0d die2=%0d, want %0d %0d", die1, die2, m_d1, m_d2);
      end
   endtask

   task automatic test_reset_mid_roll();
      exp_t e;
      apply_reset();
      press_and_push();
      for (int k = 1; k <= 21; k++) tick();
      rst = 1'b0;
      roll_btn = 1'b0;
      sb.delete();
      tick();
      tests++;
      if (num !== 5'd0 || turn !== 4'd1 || die1 !== 3'd1 || die2 !== 3'd1 ||
          busy !== 1'b0 || roll_count !== 8'd0) begin
         fails++;
         $display("FAIL mid_roll_reset: num=%0d turn=%0d d1=%0d d2=%0d busy=%0d count=%0d",
                  num, turn, die1, die2, busy, roll_count);
      end
      rst = 1'b1;
      press_and_push();
      for (int k = 1; k <= 26; k++) tick();
      m_act = 1'b0;
      e = sb.pop_front();
      tests++;
      if (num !== e.sum || turn !== 4'd1 || roll_count !== 8'd1) begin
         fails++;
         $display("FAIL post_reset_roll: num=%0d turn=%0d count=%0d, want %0d 1 1",
                  num, turn, roll_count, e.sum);
      end
   endtask

   task automatic test_gameover_idle();
      int bad;
      apply_reset();
      for (int i = 0; i < 3; i++) tick();
      game_over = 1'b1;
      tick();
      m_act = 1'b0;
      tests++;
      if (busy !== 1'b0 || num !== 5'd0 || turn !== 4'd1) begin
         fails++;
         $display("FAIL idle_game_over: busy=%0d num=%0d turn=%0d, want 0 0 1", busy, num, turn);
      end
      roll_btn = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (busy !== 1'b0 || num !== 5'd0) bad++;
      end
      tests++;
      if (bad !== 0 || die1 !== m_d1 || die2 !== m_d2) begin
         fails++;
         $display("FAIL idle_done_hold: bad=%0d die1=%0d die2=%0d, want 0 %0d %0d",
                  bad, die1, die2, m_d1, m_d2);
      end
   endtask

   task automatic test_saturation();
      int       bad_cnt;
      int       bad_turn;
      int       want;
      logic [3:0] want_turn;
      apply_reset();
      bad_cnt = 0;
      bad_turn = 0;
      want_turn = 4'd1;
      for (int i = 0; i < 257; i++) begin
         roll_btn = 1'b1;
         for (int k = 0; k < 20; k++) tick();
         roll_btn = 1'b0;
         for (int k = 0; k < 30; k++) tick();
         want = (i + 1 > 255) ? 255 : i + 1;
         if (roll_count !== 8'(want)) bad_cnt++;
         en_count = 1'b1;
         for (int k = 0; k < 4; k++) tick();
         en_count = 1'b0;
         want_turn = (want_turn == 4'd1) ? 4'd2 : 4'd1;
         if (turn !== want_turn) bad_turn++;
         for (int k = 0; k < 5; k++) tick();
      end
      tests++;
      if (bad_cnt !== 0) begin
         fails++;
         $display("FAIL count_saturate: %0d rolls with wrong roll_count (final %0d, want 255)",
                  bad_cnt, roll_count);
      end
      tests++;
      if (bad_turn !== 0) begin
         fails++;
         $display("FAIL turn_alternate: %0d handoffs with wrong turn, want 0", bad_turn);
      end
   endtask

   initial begin
      rst = 1'b0;
      roll_btn = 1'b0;
      en_count = 1'b0;
      game_over = 1'b0;
      test_reset();
      test_bounce_roll();
      test_turn_handoff();
      test_held_button();
      test_second_roll();
      test_game_over();
      test_blocked();
      test_reset_mid_roll();
      test_gameover_idle();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
